// File: rtl/bram_read_bridge.sv
// Bridges an asynchronous 128-bit line read request onto a 32-bit BRAM port:
// four word reads per line, reassembled into a registered line with a done pulse.
module bram_read_bridge #(
    parameter int ADDR_WIDTH   = 10,
    parameter int READ_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  RD_START,
    input  logic [31:0]           RD_ADDR,
    output logic [127:0]          RD_DATA,
    output logic                  RD_DONE,
    output logic                  bram_en,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    input  logic [31:0]           bram_dout,
    output logic                  busy,
    output logic                  overrun,
    output logic                  range_err
);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    localparam logic [1:0] DRAIN_LAST = 2'(READ_LATENCY - 1);

    state_t                    state;
    logic [1:0]                cnt;
    logic                      startSync1, startSync2, startPrev;
    logic                      request;
    logic                      addrBad;
    logic [ADDR_WIDTH-3:0]     base;
    logic                      baseBad;
    logic [READ_LATENCY-1:0]   validPipe;
    logic [READ_LATENCY:0]     validTap;
    logic [2*READ_LATENCY-1:0] beatPipe;
    logic [2*READ_LATENCY+1:0] beatTap;
    logic [1:0]                beatOut;
    logic [127:0]              shadow, shadowNext;

    assign request  = startSync2 & ~startPrev;
    assign addrBad  = (RD_ADDR >> (ADDR_WIDTH - 2)) != 32'd0;
    assign validTap = {validPipe, bram_en};
    assign beatTap  = {beatPipe, bram_addr[1:0]};
    assign beatOut  = beatPipe[2*READ_LATENCY-1 -: 2];

    // The last beat lands on the same edge that publishes the line, so the
    // published value must include the word being captured this cycle.
    always_comb begin
        shadowNext = shadow;
        if (validPipe[READ_LATENCY-1])
            shadowNext[{beatOut, 5'b0} +: 32] = bram_dout;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            startSync1 <= 1'b0;
            startSync2 <= 1'b0;
            startPrev  <= 1'b0;
            validPipe  <= '0;
            beatPipe   <= '0;
            shadow     <= '0;
        end else begin
            startSync1 <= RD_START;
            startSync2 <= startSync1;
            startPrev  <= startSync2;
            validPipe  <= validTap[READ_LATENCY-1:0];
            beatPipe   <= beatTap[2*READ_LATENCY-1:0];
            shadow     <= shadowNext;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            base      <= '0;
            baseBad   <= 1'b0;
            bram_en   <= 1'b0;
            bram_addr <= '0;
            RD_DATA   <= '0;
            RD_DONE   <= 1'b0;
            busy      <= 1'b0;
            overrun   <= 1'b0;
            range_err <= 1'b0;
        end else begin
            if (request && state != IDLE)
                overrun <= 1'b1;
            case (state)
                IDLE: begin
                    if (request) begin
                        state     <= ISSUE;
                        cnt       <= '0;
                        busy      <= 1'b1;
                        base      <= RD_ADDR[ADDR_WIDTH-3:0];
                        baseBad   <= addrBad;
                        bram_en   <= ~addrBad;
                        bram_addr <= addrBad ? '0 : {RD_ADDR[ADDR_WIDTH-3:0], 2'b00};
                        if (addrBad)
                            range_err <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (cnt == 2'd3) begin
                        state     <= DRAIN;
                        cnt       <= '0;
                        bram_en   <= 1'b0;
                        bram_addr <= '0;
                    end else begin
                        cnt <= cnt + 2'd1;
                        if (!baseBad)
                            bram_addr <= {base, cnt + 2'd1};
                    end
                end
                DRAIN: begin
                    if (cnt == DRAIN_LAST) begin
                        state   <= DONE;
                        cnt     <= '0;
                        RD_DONE <= 1'b1;
                        RD_DATA <= baseBad ? '0 : shadowNext;
                    end else begin
                        cnt <= cnt + 2'd1;
                    end
                end
                DONE: begin
                    if (cnt == 2'd1) begin
                        state   <= IDLE;
                        cnt     <= '0;
                        RD_DONE <= 1'b0;
                        busy    <= 1'b0;
                    end else begin
                        cnt <= cnt + 2'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bram_read_bridge.sv
// Self-checking bench for bram_read_bridge: behavioural BRAMs at latencies 1/2/3,
// a line scoreboard on RD_DONE, a vector table and hand-built corner sequences.
module tb_bram_read_bridge;

    localparam int AW  = 10;
    localparam int LAT = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          RD_START;
    logic [31:0]   RD_ADDR;

    logic [127:0]  rdData, rdData1, rdData3;
    logic          rdDone, rdDone1, rdDone3;
    logic          bramEn, bramEn1, bramEn3;
    logic [AW-1:0] bramAddr, bramAddr1, bramAddr3;
    logic [31:0]   bramDout, bramDout1, bramDout3;
    logic          busy, busy1, busy3;
    logic          overrun, overrun1, overrun3;
    logic          rangeErr, rangeErr1, rangeErr3;

    int            checks = 0;
    int            failures = 0;
    logic [127:0]  sbq[$];
    logic          prevDone = 1'b0;
    int            rise1, rise3;
    logic [127:0]  data1, data3;

    logic [31:0]   mem [1024];
    logic [AW:0]   hist1 [1];
    logic [AW:0]   hist2 [2];
    logic [AW:0]   hist3 [3];

    typedef struct {
        logic [31:0]  addr;
        logic [127:0] expData;
        logic         expBad;
    } vec_t;
    vec_t vecs [6];

    always #5 clk = ~clk;

    bram_read_bridge #(.ADDR_WIDTH(AW), .READ_LATENCY(LAT)) dut (
        .clk(clk), .rst(rst), .RD_START(RD_START), .RD_ADDR(RD_ADDR),
        .RD_DATA(rdData), .RD_DONE(rdDone), .bram_en(bramEn), .bram_addr(bramAddr),
        .bram_dout(bramDout), .busy(busy), .overrun(overrun), .range_err(rangeErr));

    bram_read_bridge #(.ADDR_WIDTH(AW), .READ_LATENCY(1)) dutLat1 (
        .clk(clk), .rst(rst), .RD_START(RD_START), .RD_ADDR(RD_ADDR),
        .RD_DATA(rdData1), .RD_DONE(rdDone1), .bram_en(bramEn1), .bram_addr(bramAddr1),
        .bram_dout(bramDout1), .busy(busy1), .overrun(overrun1), .range_err(rangeErr1));

    bram_read_bridge #(.ADDR_WIDTH(AW), .READ_LATENCY(3)) dutLat3 (
        .clk(clk), .rst(rst), .RD_START(RD_START), .RD_ADDR(RD_ADDR),
        .RD_DATA(rdData3), .RD_DONE(rdDone3), .bram_en(bramEn3), .bram_addr(bramAddr3),
        .bram_dout(bramDout3), .busy(busy3), .overrun(overrun3), .range_err(rangeErr3));

    // BRAM models: data appears exactly N cycles after the enable cycle, garbage otherwise.
    always @(posedge clk) begin
        hist1[0] <= {bramEn1, bramAddr1};
        hist2[0] <= {bramEn, bramAddr};
        hist2[1] <= hist2[0];
        hist3[0] <= {bramEn3, bramAddr3};
        hist3[1] <= hist3[0];
        hist3[2] <= hist3[1];
    end
    assign bramDout1 = hist1[0][AW] ? mem[hist1[0][AW-1:0]] : 32'hDEAD_BEEF;
    assign bramDout  = hist2[1][AW] ? mem[hist2[1][AW-1:0]] : 32'hDEAD_BEEF;
    assign bramDout3 = hist3[2][AW] ? mem[hist3[2][AW-1:0]] : 32'hDEAD_BEEF;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] expLine(input logic [31:0] a);
        int unsigned w;
        if (a >= 32'(2 ** (AW - 2)))
            return '0;
        w = a * 4;
        return {mem[w+3], mem[w+2], mem[w+1], mem[w]};
    endfunction

    always @(negedge clk) begin
        if (rdDone && !prevDone) begin
            if (sbq.size() == 0) begin
                chk("sb_unexpected_done", rdDone, 1'b0);
            end else begin
                chk("sb_rd_data", rdData, sbq.pop_front());
            end
        end
        prevDone <= rdDone;
    end

    task automatic doReset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic expectIdle(input int n);
        int hits = 0;
        repeat (n) begin
            @(posedge clk); #1;
            if (busy || rdDone || bramEn) hits++;
        end
        chk("stay_idle", hits, 0);
    endtask

    // One full transaction on the main DUT, checked cycle by cycle from cycle 1.
    task automatic doRead(input logic [31:0] addr, input logic [127:0] expData,
                          input logic expBad, input bit preRaised, input int raiseAt,
                          input logic [31:0] raiseAddr, output int waits);
        bit            got = 1'b0;
        logic [AW-1:0] expAddr;
        logic          expEn;
        sbq.push_back(expData);
        if (!preRaised) begin
            RD_ADDR  = addr;
            RD_START = 1'b1;
        end
        waits = 0;
        while (!got && waits < 10) begin
            @(posedge clk); #1;
            waits++;
            got = busy;
        end
        if (!got) begin
            chk("start_timeout", busy, 1'b1);
            return;
        end
        RD_START = 1'b0;
        rise1 = 0;
        rise3 = 0;
        for (int c = 1; c <= 7 + LAT; c++) begin
            if (c > 1) begin
                @(posedge clk); #1;
            end
            expEn   = (c <= 4) && !expBad;
            expAddr = expEn ? {addr[AW-3:0], 2'(c - 1)} : '0;
            chk($sformatf("busy_c%0d", c), busy, c <= 6 + LAT);
            chk($sformatf("bram_en_c%0d", c), bramEn, expEn);
            chk($sformatf("bram_addr_c%0d", c), bramAddr, expAddr);
            chk($sformatf("rd_done_c%0d", c), rdDone, (c == 5 + LAT) || (c == 6 + LAT));
            if (rdDone1 && rise1 == 0) begin
                rise1 = c;
                data1 = rdData1;
            end
            if (rdDone3 && rise3 == 0) begin
                rise3 = c;
                data3 = rdData3;
            end
            if (raiseAt == c) begin
                RD_ADDR  = raiseAddr;
                RD_START = 1'b1;
            end
        end
        chk("rd_data_hold", rdData, expData);
    endtask

    initial begin
        int   w;
        logic rangeSticky;

        for (int i = 0; i < 1024; i++)
            mem[i] = 32'(i) * 32'h0001_0003 + 32'h5A5A_0000;
        mem[20] = 32'h1111_1111;
        mem[21] = 32'h2222_2222;
        mem[22] = 32'h3333_3333;
        mem[23] = 32'h4444_4444;

        vecs[0] = '{32'd5, 128'h44444444_33333333_22222222_11111111, 1'b0};
        vecs[1] = '{32'd0, expLine(32'd0), 1'b0};
        vecs[2] = '{32'd255, expLine(32'd255), 1'b0};
        vecs[3] = '{32'd256, 128'h0, 1'b1};
        vecs[4] = '{32'h1000_0005, 128'h0, 1'b1};
        vecs[5] = '{32'd7, expLine(32'd7), 1'b0};

        rst      = 1'b1;
        RD_START = 1'b0;
        RD_ADDR  = '0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        chk("rst_rd_data", rdData, 128'h0);
        chk("rst_rd_done", rdDone, 1'b0);
        chk("rst_bram_en", bramEn, 1'b0);
        chk("rst_bram_addr", bramAddr, '0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_overrun", overrun, 1'b0);
        chk("rst_range_err", rangeErr, 1'b0);
        rst = 1'b0;
        @(posedge clk); #1;

        rangeSticky = 1'b0;
        for (int i = 0; i < 6; i++) begin
            doRead(vecs[i].addr, vecs[i].expData, vecs[i].expBad, 1'b0, 0, '0, w);
            rangeSticky = rangeSticky | vecs[i].expBad;
            chk($sformatf("range_err_v%0d", i), rangeErr, rangeSticky);
            chk($sformatf("overrun_v%0d", i), overrun, 1'b0);
            chk($sformatf("lat1_done_cycle_v%0d", i), rise1, 6);
            chk($sformatf("lat1_data_v%0d", i), data1, vecs[i].expData);
            chk($sformatf("lat3_done_cycle_v%0d", i), rise3, 8);
            chk($sformatf("lat3_data_v%0d", i), data3, vecs[i].expData);
            repeat (2) @(posedge clk);
            #1;
        end

        // Second rise at cycle 3 must be dropped and flagged.
        doReset();
        doRead(32'd5, expLine(32'd5), 1'b0, 1'b0, 3, 32'd5, w);
        RD_START = 1'b0;
        chk("overrun_set", overrun, 1'b1);
        expectIdle(12);
        chk("overrun_sticky", overrun, 1'b1);

        // Reset in cycle 3 aborts the read; late BRAM data must not surface.
        doReset();
        RD_ADDR  = 32'd9;
        RD_START = 1'b1;
        w = 0;
        while (!busy && w < 10) begin
            @(posedge clk); #1;
            w++;
        end
        chk("abort_started", busy, 1'b1);
        RD_START = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        chk("abort_rd_data", rdData, 128'h0);
        chk("abort_rd_done", rdDone, 1'b0);
        chk("abort_bram_en", bramEn, 1'b0);
        chk("abort_bram_addr", bramAddr, '0);
        chk("abort_busy", busy, 1'b0);
        chk("abort_overrun", overrun, 1'b0);
        chk("abort_range_err", rangeErr, 1'b0);
        rst = 1'b0;
        expectIdle(12);
        doRead(32'd1, expLine(32'd1), 1'b0, 1'b0, 0, '0, w);
        repeat (2) @(posedge clk);
        #1;

        // Back-to-back: second request detected in cycle 7+LAT is accepted.
        doReset();
        doRead(32'd0, expLine(32'd0), 1'b0, 1'b0, 7, 32'd1, w);
        doRead(32'd1, expLine(32'd1), 1'b0, 1'b1, 0, '0, w);
        chk("b2b_immediate_start", w, 1);
        RD_START = 1'b0;
        chk("b2b_overrun", overrun, 1'b0);
        repeat (2) @(posedge clk);
        #1;

        // RD_START high across reset release: one request, accepted on the 3rd edge.
        rst      = 1'b1;
        RD_START = 1'b1;
        RD_ADDR  = 32'd3;
        repeat (2) begin
            @(posedge clk); #1;
        end
        rst = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        chk("held_not_early", busy, 1'b0);
        doRead(32'd3, expLine(32'd3), 1'b0, 1'b1, 0, '0, w);
        chk("held_third_edge", w, 1);
        expectIdle(10);
        chk("held_overrun", overrun, 1'b0);

        chk("sb_empty", sbq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
